// File: rtl/ml_peak_detect_pkg.sv
// rtl/ml_peak_detect_pkg.sv - shared constants and state encoding for the ML peak detector
package ml_peak_detect_pkg;

    localparam int ML_MW    = 24;
    localparam int ML_WIN   = 320;
    localparam int ML_GUARD = 64;
    localparam int ML_IW    = 9;

    localparam logic signed [ML_MW-1:0] ML_METRIC_MIN = {1'b1, {(ML_MW-1){1'b0}}};

    typedef enum logic [1:0] {
        PD_IDLE    = 2'd0,
        PD_SEARCH  = 2'd1,
        PD_CONFIRM = 2'd2,
        PD_REPORT  = 2'd3
    } pd_state_e;

endpackage

// File: rtl/ml_peak_track.sv
// rtl/ml_peak_track.sv - running maximum of the ML metric with its index and guard counter
module ml_peak_track
    import ml_peak_detect_pkg::*;
#(
    parameter int MW    = ML_MW,
    parameter int IW    = ML_IW,
    parameter int GUARD = ML_GUARD
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic signed [MW-1:0] dat,
    input  logic [IW-1:0]        idx,
    output logic signed [MW-1:0] best_val,
    output logic [IW-1:0]        best_idx,
    output logic                 upd,
    output logic                 guard_hit
);

    localparam logic signed [MW-1:0] VAL_MIN = {1'b1, {(MW-1){1'b0}}};

    logic [IW-1:0] gcnt;

    // Strict compare: an equal value never displaces the earlier index.
    assign upd       = dat > best_val;
    assign guard_hit = (gcnt == IW'(GUARD - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            best_val <= VAL_MIN;
            best_idx <= '0;
            gcnt     <= '0;
        end else if (en) begin
            if (upd) begin
                best_val <= dat;
                best_idx <= idx;
                gcnt     <= '0;
            end else begin
                gcnt <= gcnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ml_peak_detect.sv
// rtl/ml_peak_detect.sv - windowed, guard-confirmed peak search over the ML timing metric
module ml_peak_detect
    import ml_peak_detect_pkg::*;
#(
    parameter int MW    = ML_MW,
    parameter int WIN   = ML_WIN,
    parameter int GUARD = ML_GUARD,
    parameter int IW    = ML_IW
) (
    input  logic                 CLK_I,
    input  logic                 RST_I,
    input  logic                 CYC_I,
    input  logic                 STB_I,
    input  logic signed [MW-1:0] DAT_I,
    input  logic signed [MW-1:0] THR_I,
    output logic                 ACK_O,
    output logic                 STB_O,
    output logic signed [MW-1:0] DAT_O,
    output logic [IW-1:0]        IDX_O,
    output logic                 FOUND_O,
    input  logic                 ACK_I
);

    pd_state_e             state, state_nxt;
    logic                  found, found_nxt;
    logic [IW-1:0]         cnt;
    logic signed [MW-1:0]  thr;
    logic signed [MW-1:0]  best_val;
    logic [IW-1:0]         best_idx;
    logic                  upd, guard_hit;
    logic                  acc, last, cand, arm, trk_en;

    assign acc    = STB_I && ACK_O;
    assign last   = (cnt == IW'(WIN - 1));
    assign cand   = DAT_I > thr;
    assign arm    = (state == PD_IDLE) && CYC_I;
    // In SEARCH best_val is still the minimum, so a candidate always registers as a new best.
    assign trk_en = acc && CYC_I &&
                    (((state == PD_SEARCH) && cand) || (state == PD_CONFIRM));

    ml_peak_track #(.MW(MW), .IW(IW), .GUARD(GUARD)) u_track (
        .clk       (CLK_I),
        .rst       (RST_I),
        .clr       (arm),
        .en        (trk_en),
        .dat       (DAT_I),
        .idx       (cnt),
        .best_val  (best_val),
        .best_idx  (best_idx),
        .upd       (upd),
        .guard_hit (guard_hit)
    );

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state <= PD_IDLE;
            found <= 1'b0;
        end else begin
            state <= state_nxt;
            found <= found_nxt;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            cnt <= '0;
            thr <= '0;
        end else if (arm) begin
            cnt <= '0;
            thr <= THR_I;
        end else if (acc) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        found_nxt = found;
        case (state)
            PD_IDLE: begin
                if (CYC_I) begin
                    state_nxt = PD_SEARCH;
                    found_nxt = 1'b0;
                end
            end
            PD_SEARCH: begin
                if (!CYC_I) begin
                    state_nxt = PD_IDLE;
                end else if (acc && cand) begin
                    state_nxt = last ? PD_REPORT : PD_CONFIRM;
                    found_nxt = 1'b1;
                end else if (acc && last) begin
                    state_nxt = PD_REPORT;
                    found_nxt = 1'b0;
                end
            end
            PD_CONFIRM: begin
                if (!CYC_I) begin
                    state_nxt = PD_IDLE;
                end else if (acc && (last || (!upd && guard_hit))) begin
                    state_nxt = PD_REPORT;
                    found_nxt = 1'b1;
                end
            end
            PD_REPORT: begin
                if (ACK_I) begin
                    state_nxt = PD_IDLE;
                end
            end
            default: state_nxt = PD_IDLE;
        endcase
    end

    // Result fields are decoded from held registers, so they stay frozen until acknowledged.
    always_comb begin
        ACK_O   = (state == PD_SEARCH) || (state == PD_CONFIRM);
        STB_O   = (state == PD_REPORT);
        FOUND_O = STB_O && found;
        DAT_O   = FOUND_O ? best_val : '0;
        IDX_O   = FOUND_O ? best_idx : '0;
    end

endmodule
